// File: rtl/share_pkg.sv
// Shared types and constants for the four-share input splitter.
package share_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RND = 3'd1,
    MASK2    = 3'd2,
    MASK3    = 3'd3,
    OUT      = 3'd4
  } split_state_t;

  localparam int unsigned NSHARES = 4;

endpackage

// File: rtl/share_mask_stage.sv
// One register stage that folds a single mask into the running masked secret.
module share_mask_stage #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] t_in,
  input  logic [N-1:0] mask,
  output logic [N-1:0] t_out
);

  logic [N-1:0] t_d;
  logic [N-1:0] t_q;

  always_comb begin
    t_d = t_q;
    if (clr) begin
      t_d = '0;
    end else if (en) begin
      t_d = t_in ^ mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  assign t_out = t_q;

endmodule

// File: rtl/share_split4.sv
// Splits an unmasked N-bit value into four XOR shares, adding one fresh mask per
// register stage so the plain value never meets more than one mask in a cycle.
module share_split4
  import share_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  input  logic [3*N-1:0] rnd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   sh1,
  output logic [N-1:0]   sh2,
  output logic [N-1:0]   sh3,
  output logic [N-1:0]   sh4
);

  localparam int unsigned RW = (NSHARES - 1) * N;

  split_state_t state_q, state_d;

  logic [N-1:0]  d_q, d_d;
  logic [RW-1:0] r_q, r_d;
  logic [N-1:0]  sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d, sh4_q, sh4_d;
  logic [N-1:0]  r0_q, r1_q, r2_q;
  logic          in_hs, rnd_hs, out_hs;
  logic          t_en, t_clr;
  logic [N-1:0]  t_in, t_mask, t_q;

  assign r0_q   = r_q[N-1:0];
  assign r1_q   = r_q[2*N-1:N];
  assign r2_q   = r_q[3*N-1:2*N];
  assign in_hs  = in_valid & in_ready;
  assign rnd_hs = rnd_valid & rnd_ready;
  assign out_hs = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (in_hs)  state_d = WAIT_RND;
      WAIT_RND: if (rnd_hs) state_d = MASK2;
      MASK2:    state_d = MASK3;
      MASK3:    state_d = OUT;
      OUT:      if (out_hs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake outputs decode the state flop only, never the partner's ready
  always_comb begin
    in_ready  = 1'b0;
    rnd_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:     in_ready  = 1'b1;
      WAIT_RND: rnd_ready = 1'b1;
      OUT:      out_valid = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: plain value is wiped the moment the first mask is applied
  always_comb begin
    d_d    = d_q;
    r_d    = r_q;
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    sh3_d  = sh3_q;
    sh4_d  = sh4_q;
    t_en   = 1'b0;
    t_clr  = 1'b0;
    t_in   = '0;
    t_mask = '0;
    case (state_q)
      IDLE: begin
        if (in_hs) d_d = in_data;
      end
      WAIT_RND: begin
        if (rnd_hs) begin
          r_d    = rnd;
          d_d    = '0;
          t_en   = 1'b1;
          t_in   = d_q;
          t_mask = rnd[N-1:0];
        end
      end
      MASK2: begin
        t_en   = 1'b1;
        t_in   = t_q;
        t_mask = r1_q;
      end
      MASK3: begin
        sh1_d = r0_q;
        sh2_d = r1_q;
        sh3_d = r2_q;
        sh4_d = t_q ^ r2_q;
      end
      OUT: begin
        if (out_hs) begin
          r_d   = '0;
          t_clr = 1'b1;
          sh1_d = '0;
          sh2_d = '0;
          sh3_d = '0;
          sh4_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      r_q   <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      sh3_q <= '0;
      sh4_q <= '0;
    end else begin
      d_q   <= d_d;
      r_q   <= r_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      sh3_q <= sh3_d;
      sh4_q <= sh4_d;
    end
  end

  share_mask_stage #(.N(N)) u_mask (
    .clk   (clk),
    .rst   (rst),
    .en    (t_en),
    .clr   (t_clr),
    .t_in  (t_in),
    .mask  (t_mask),
    .t_out (t_q)
  );

  assign sh1 = sh1_q;
  assign sh2 = sh2_q;
  assign sh3 = sh3_q;
  assign sh4 = sh4_q;

endmodule

// File: tb/tb_share_split4.sv
// Bench for share_split4: N=4 and N=64 instances driven in lockstep against a
// transaction-level reference model, plus directed vectors with known shares.
module tb_share_split4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, rnd_valid, out_ready;
  logic [3:0]   in_data4;
  logic [11:0]  rnd4;
  logic [63:0]  in_data64;
  logic [191:0] rnd64;

  logic        in_ready4, rnd_ready4, out_valid4;
  logic [3:0]  sh1_4, sh2_4, sh3_4, sh4_4;
  logic        in_ready64, rnd_ready64, out_valid64;
  logic [63:0] sh1_64, sh2_64, sh3_64, sh4_64;

  share_split4 #(.N(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data4),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready4), .rnd(rnd4),
    .out_valid(out_valid4), .out_ready(out_ready),
    .sh1(sh1_4), .sh2(sh2_4), .sh3(sh3_4), .sh4(sh4_4)
  );

  share_split4 #(.N(64)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready64), .rnd(rnd64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .sh1(sh1_64), .sh2(sh2_64), .sh3(sh3_64), .sh4(sh4_64)
  );

  typedef struct {
    logic [3:0]  din;
    logic [11:0] rnd;
    logic [3:0]  s1, s2, s3, s4;
  } vec_t;

  vec_t tbl[5];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: one transaction in flight, tracked by phase flags
  bit           busy = 1'b0;
  bit           rtaken = 1'b0;
  int           cyc = 0;
  int           rnd_cyc = 0;
  logic [3:0]   md4 = '0;
  logic [11:0]  mr4 = '0;
  logic [63:0]  md64 = '0;
  logic [191:0] mr64 = '0;
  int           n_in_dut = 0;
  int           n_rnd_dut = 0;
  int           n_out_dut = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One clock: check DUT against model mid-cycle, then advance the model
  task automatic step();
    logic ov, hi, hr, ho, r;
    logic [3:0]  e4_0, e4_1, e4_2, e4_3;
    logic [63:0] e64_0, e64_1, e64_2, e64_3;
    @(negedge clk);
    ov = busy && rtaken && (cyc - rnd_cyc >= 3);
    e4_0  = mr4[3:0];
    e4_1  = mr4[7:4];
    e4_2  = mr4[11:8];
    e4_3  = md4 ^ e4_0 ^ e4_1 ^ e4_2;
    e64_0 = mr64[63:0];
    e64_1 = mr64[127:64];
    e64_2 = mr64[191:128];
    e64_3 = md64 ^ e64_0 ^ e64_1 ^ e64_2;
    chk("in_ready4",   64'(in_ready4),   64'(!busy));
    chk("rnd_ready4",  64'(rnd_ready4),  64'(busy && !rtaken));
    chk("out_valid4",  64'(out_valid4),  64'(ov));
    chk("in_ready64",  64'(in_ready64),  64'(!busy));
    chk("rnd_ready64", 64'(rnd_ready64), 64'(busy && !rtaken));
    chk("out_valid64", 64'(out_valid64), 64'(ov));
    chk("sh1_4", 64'(sh1_4), 64'(ov ? e4_0 : 4'h0));
    chk("sh2_4", 64'(sh2_4), 64'(ov ? e4_1 : 4'h0));
    chk("sh3_4", 64'(sh3_4), 64'(ov ? e4_2 : 4'h0));
    chk("sh4_4", 64'(sh4_4), 64'(ov ? e4_3 : 4'h0));
    chk("sh1_64", sh1_64, ov ? e64_0 : 64'h0);
    chk("sh2_64", sh2_64, ov ? e64_1 : 64'h0);
    chk("sh3_64", sh3_64, ov ? e64_2 : 64'h0);
    chk("sh4_64", sh4_64, ov ? e64_3 : 64'h0);
    chk("d_q4",  64'(u4.d_q), 64'((busy && !rtaken) ? md4 : 4'h0));
    chk("d_q64", u64.d_q, (busy && !rtaken) ? md64 : 64'h0);
    if (!rst && in_valid && in_ready4) n_in_dut++;
    if (!rst && rnd_valid && rnd_ready4) n_rnd_dut++;
    if (!rst && out_valid4 && out_ready) n_out_dut++;
    r  = rst;
    hi = in_valid && !busy;
    hr = rnd_valid && busy && !rtaken;
    ho = out_ready && ov;
    @(posedge clk);
    #1;
    if (r) begin
      busy   = 1'b0;
      rtaken = 1'b0;
    end else begin
      if (ho) begin
        busy   = 1'b0;
        rtaken = 1'b0;
      end
      if (hi) begin
        busy = 1'b1;
        md4  = in_data4;
        md64 = in_data64;
      end
      if (hr) begin
        rtaken  = 1'b1;
        rnd_cyc = cyc;
        mr4     = rnd4;
        mr64    = rnd64;
      end
    end
    cyc++;
  endtask

  task automatic chk_shares_zero(string name);
    chk(name, 64'({sh1_4, sh2_4, sh3_4, sh4_4}), 64'h0);
  endtask

  initial begin
    int hold, start_out, budget;
    int n_in0, n_rnd0, n_out0;
    vec_t v;

    tbl[0] = '{4'hA, 12'h35C, 4'hC, 4'h5, 4'h3, 4'h0};
    tbl[1] = '{4'h7, 12'h000, 4'h0, 4'h0, 4'h0, 4'h7};
    tbl[2] = '{4'hF, 12'h124, 4'h4, 4'h2, 4'h1, 4'h8};
    tbl[3] = '{4'h0, 12'hFFF, 4'hF, 4'hF, 4'hF, 4'hF};
    tbl[4] = '{4'h5, 12'hA06, 4'h6, 4'h0, 4'hA, 4'h9};

    rst = 1'b1;
    in_valid = 1'b0;
    rnd_valid = 1'b1;
    out_ready = 1'b0;
    in_data4 = '0;
    in_data64 = '0;
    rnd4 = '0;
    rnd64 = '0;
    repeat (2) step();
    rst = 1'b0;
    rnd_valid = 1'b0;
    chk("reset_in_ready",  64'(in_ready4),  64'h1);
    chk("reset_rnd_ready", 64'(rnd_ready4), 64'h0);
    chk("reset_out_valid", 64'(out_valid4), 64'h0);
    chk_shares_zero("reset_shares");

    // Reset asserted for three cycles while in MASK2 discards the transaction
    in_valid = 1'b1;
    in_data4 = 4'hA;
    in_data64 = rand64();
    step();
    in_valid = 1'b0;
    rnd_valid = 1'b1;
    rnd4 = 12'h35C;
    rnd64 = {rand64(), rand64(), rand64()};
    step();
    rnd_valid = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("midrst_in_ready",  64'(in_ready4),  64'h1);
    chk("midrst_out_valid", 64'(out_valid4), 64'h0);
    chk_shares_zero("midrst_shares");
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;

    // Directed vectors with hand-computed shares
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      in_valid = 1'b1;
      in_data4 = v.din;
      in_data64 = rand64();
      step();
      in_valid = 1'b0;
      rnd_valid = 1'b1;
      rnd4 = v.rnd;
      rnd64 = {rand64(), rand64(), rand64()};
      step();
      rnd_valid = 1'b0;
      step();
      chk("lat_early_out_valid", 64'(out_valid4), 64'h0);
      step();
      hold = (i == 0) ? 5 : 1;
      for (int k = 0; k < hold; k++) begin
        chk("tbl_out_valid", 64'(out_valid4), 64'h1);
        chk("tbl_shares", 64'({sh1_4, sh2_4, sh3_4, sh4_4}), 64'({v.s1, v.s2, v.s3, v.s4}));
        chk("tbl_xor", 64'(sh1_4 ^ sh2_4 ^ sh3_4 ^ sh4_4), 64'(v.din));
        if (k < hold - 1) step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_out_in_ready", 64'(in_ready4), 64'h1);
      chk_shares_zero("post_out_shares");
    end

    // Randomness withheld: block waits in WAIT_RND
    in_valid = 1'b1;
    in_data4 = 4'h3;
    in_data64 = rand64();
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("wait_rnd_ready", 64'(rnd_ready4), 64'h1);
      chk("wait_in_ready",  64'(in_ready4),  64'h0);
      chk("wait_out_valid", 64'(out_valid4), 64'h0);
    end
    rnd_valid = 1'b1;
    rnd4 = 12'h9B2;
    rnd64 = {rand64(), rand64(), rand64()};
    step();
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Back-to-back: all valids and ready held high, one transaction per 5 cycles
    n_in0 = n_in_dut;
    n_rnd0 = n_rnd_dut;
    n_out0 = n_out_dut;
    in_valid = 1'b1;
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      in_data4 = 4'($urandom);
      in_data64 = rand64();
      rnd4 = 12'($urandom);
      rnd64 = {rand64(), rand64(), rand64()};
      step();
    end
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    chk("b2b_in_count",  64'(n_in_dut - n_in0),   64'd10);
    chk("b2b_rnd_count", 64'(n_rnd_dut - n_rnd0), 64'd10);
    chk("b2b_out_count", 64'(n_out_dut - n_out0), 64'd10);

    // Random traffic against the model
    start_out = n_out_dut;
    budget = 0;
    while ((n_out_dut - start_out) < 1000 && budget < 20000) begin
      in_valid  = ($urandom % 4) != 0;
      rnd_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 500) == 0;
      in_data4  = 4'($urandom);
      in_data64 = rand64();
      rnd4      = 12'($urandom);
      rnd64     = {rand64(), rand64(), rand64()};
      step();
      budget++;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    rnd_valid = 1'b0;
    chk("random_txn_count_reached", 64'((n_out_dut - start_out) >= 1000), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
